// File: rtl/pll_loop_filter.sv
// Second-order PI loop filter for the data-separator DPLL: gain-scheduled
// integrator + proportional path, saturated NCO increment, lock/unlock FSM.
// Optional statistics outputs are enabled by defining PLL_LOOP_FILTER_STATS_EN.
module pll_loop_filter #(
  parameter logic [31:0] NOMINAL_FREQ = 32'h0147AE14,
  parameter logic [31:0] INT_LIMIT    = 32'h00080000,
  parameter logic [31:0] FREQ_RANGE   = 32'h00100000,
  parameter int unsigned ACQ_BOOST    = 2,
  parameter int unsigned LOCK_COUNT   = 16,
  parameter int unsigned UNLOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] phase_error,
  input  logic        error_valid,
  input  logic [1:0]  margin_zone,
  input  logic [31:0] center_freq,
  input  logic [3:0]  kp_shift,
  input  logic [3:0]  ki_shift,
  input  logic        freeze,
  input  logic        integ_clear,
  output logic [31:0] nco_freq,
  output logic        freq_valid,
  output logic        locked,
  output logic [1:0]  loop_state,
`ifdef PLL_LOOP_FILTER_STATS_EN
  output logic [15:0] unlock_count,
  output logic [15:0] peak_error,
`endif
  output logic        saturated
);

  typedef enum logic [1:0] {
    ST_ACQUIRE = 2'b00,
    ST_LOCKED  = 2'b01,
    ST_HOLD    = 2'b10
  } state_t;

  localparam logic [1:0] ZONE_ON_TIME = 2'b01;

  state_t state_reg, state_next;
  state_t resume_reg, resume_next;
  logic [7:0] hit_cnt_reg, hit_cnt_next;
  logic [7:0] miss_cnt_reg, miss_cnt_next;
  logic       unlock_event;

  logic               s0_valid_reg;
  logic signed [15:0] s0_err_reg;
  logic [1:0]         s0_zone_reg;

  logic               s1_valid_reg;
  logic signed [31:0] integ_reg;
  logic signed [31:0] prop_reg;
  logic               s1_sat_reg;

  logic [31:0] nco_freq_reg;
  logic        freq_valid_reg;
  logic        saturated_reg;

  logic accept;
  assign accept = error_valid && !freeze && !integ_clear;

  // Gains follow the state the sample belongs to, even if HOLD was just entered.
  state_t gain_state;
  logic   boost;
  logic [3:0] kp_eff, ki_eff;
  assign gain_state = (state_reg == ST_HOLD) ? resume_reg : state_reg;
  assign boost      = (gain_state == ST_ACQUIRE);
  assign kp_eff = !boost ? kp_shift :
                  (kp_shift > 4'(ACQ_BOOST)) ? (kp_shift - 4'(ACQ_BOOST)) : 4'd0;
  assign ki_eff = !boost ? ki_shift :
                  (ki_shift > 4'(ACQ_BOOST)) ? (ki_shift - 4'(ACQ_BOOST)) : 4'd0;

  logic signed [31:0] scaled, prop, istep;
  assign scaled = {{8{s0_err_reg[15]}}, s0_err_reg, 8'h00};
  assign prop   = scaled >>> kp_eff;
  assign istep  = scaled >>> ki_eff;

  // Integrator sum carried in 33 bits so the clamp sees the true value.
  logic signed [32:0] integ_sum, int_hi, int_lo;
  logic signed [31:0] integ_clamped;
  logic               integ_sat;
  assign integ_sum = {integ_reg[31], integ_reg} + {istep[31], istep};
  assign int_hi    = {1'b0, INT_LIMIT};
  assign int_lo    = -int_hi;

  always_comb begin
    integ_clamped = integ_sum[31:0];
    integ_sat     = 1'b0;
    if (integ_sum > int_hi) begin
      integ_clamped = int_hi[31:0];
      integ_sat     = 1'b1;
    end else if (integ_sum < int_lo) begin
      integ_clamped = int_lo[31:0];
      integ_sat     = 1'b1;
    end
  end

  // Center frequency is treated as unsigned; offsets are signed.
  logic signed [33:0] center_ext, freq_sum, freq_hi, freq_lo;
  logic [31:0]        nco_clamped;
  logic               freq_sat;
  assign center_ext = {2'b00, center_freq};
  assign freq_sum   = center_ext + {{2{integ_reg[31]}}, integ_reg}
                                 + {{2{prop_reg[31]}}, prop_reg};
  assign freq_hi    = center_ext + {2'b00, FREQ_RANGE};
  assign freq_lo    = center_ext - {2'b00, FREQ_RANGE};

  always_comb begin
    nco_clamped = freq_sum[31:0];
    freq_sat    = 1'b0;
    if (freq_sum > freq_hi) begin
      nco_clamped = freq_hi[31:0];
      freq_sat    = 1'b1;
    end else if (freq_sum < freq_lo) begin
      nco_clamped = freq_lo[31:0];
      freq_sat    = 1'b1;
    end
  end

  always_comb begin
    state_next    = state_reg;
    resume_next   = resume_reg;
    hit_cnt_next  = hit_cnt_reg;
    miss_cnt_next = miss_cnt_reg;
    unlock_event  = 1'b0;
    if (integ_clear) begin
      state_next    = ST_ACQUIRE;
      resume_next   = ST_ACQUIRE;
      hit_cnt_next  = 8'd0;
      miss_cnt_next = 8'd0;
      unlock_event  = (state_reg == ST_LOCKED);
    end else if (freeze) begin
      if (state_reg != ST_HOLD) begin
        resume_next = state_reg;
      end
      state_next = ST_HOLD;
    end else if (state_reg == ST_HOLD) begin
      state_next = resume_reg;
    end else if (s0_valid_reg) begin
      case (state_reg)
        ST_ACQUIRE: begin
          if (s0_zone_reg == ZONE_ON_TIME) begin
            if (hit_cnt_reg + 8'd1 == 8'(LOCK_COUNT)) begin
              state_next    = ST_LOCKED;
              hit_cnt_next  = 8'd0;
              miss_cnt_next = 8'd0;
            end else begin
              hit_cnt_next = hit_cnt_reg + 8'd1;
            end
          end else begin
            hit_cnt_next = 8'd0;
          end
        end
        ST_LOCKED: begin
          if (s0_zone_reg != ZONE_ON_TIME) begin
            if (miss_cnt_reg + 8'd1 == 8'(UNLOCK_COUNT)) begin
              state_next    = ST_ACQUIRE;
              hit_cnt_next  = 8'd0;
              miss_cnt_next = 8'd0;
              unlock_event  = 1'b1;
            end else begin
              miss_cnt_next = miss_cnt_reg + 8'd1;
            end
          end else begin
            miss_cnt_next = 8'd0;
          end
        end
        default: state_next = state_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ST_ACQUIRE;
      resume_reg   <= ST_ACQUIRE;
      hit_cnt_reg  <= 8'd0;
      miss_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      resume_reg   <= resume_next;
      hit_cnt_reg  <= hit_cnt_next;
      miss_cnt_reg <= miss_cnt_next;
    end
  end

  // Three-register pipeline: capture, integrate, output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_valid_reg   <= 1'b0;
      s0_err_reg     <= 16'sd0;
      s0_zone_reg    <= 2'b00;
      s1_valid_reg   <= 1'b0;
      integ_reg      <= 32'sd0;
      prop_reg       <= 32'sd0;
      s1_sat_reg     <= 1'b0;
      nco_freq_reg   <= NOMINAL_FREQ;
      freq_valid_reg <= 1'b0;
      saturated_reg  <= 1'b0;
    end else if (integ_clear) begin
      s0_valid_reg   <= 1'b0;
      s1_valid_reg   <= 1'b0;
      integ_reg      <= 32'sd0;
      prop_reg       <= 32'sd0;
      s1_sat_reg     <= 1'b0;
      nco_freq_reg   <= center_freq;
      freq_valid_reg <= 1'b0;
      saturated_reg  <= 1'b0;
    end else begin
      s0_valid_reg <= accept;
      if (accept) begin
        s0_err_reg  <= phase_error;
        s0_zone_reg <= margin_zone;
      end
      s1_valid_reg <= s0_valid_reg;
      if (s0_valid_reg) begin
        integ_reg  <= integ_clamped;
        prop_reg   <= prop;
        s1_sat_reg <= integ_sat;
      end
      freq_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        nco_freq_reg  <= nco_clamped;
        saturated_reg <= s1_sat_reg | freq_sat;
      end
    end
  end

`ifdef PLL_LOOP_FILTER_STATS_EN
  logic [15:0] unlock_count_reg;
  logic [15:0] peak_error_reg;
  logic [15:0] abs_err;

  // |-32768| is reported as 32767 so the result stays within 15 magnitude bits.
  always_comb begin
    abs_err = phase_error;
    if (phase_error[15]) begin
      abs_err = (phase_error == 16'h8000) ? 16'h7FFF : (~phase_error + 16'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      unlock_count_reg <= 16'd0;
      peak_error_reg   <= 16'd0;
    end else begin
      if (unlock_event && unlock_count_reg != 16'hFFFF) begin
        unlock_count_reg <= unlock_count_reg + 16'd1;
      end
      if (integ_clear) begin
        peak_error_reg <= 16'd0;
      end else if (accept && abs_err > peak_error_reg) begin
        peak_error_reg <= abs_err;
      end
    end
  end

  assign unlock_count = unlock_count_reg;
  assign peak_error   = peak_error_reg;
`endif

  assign nco_freq   = nco_freq_reg;
  assign freq_valid = freq_valid_reg;
  assign saturated  = saturated_reg;
  assign locked     = (state_reg == ST_LOCKED);
  assign loop_state = state_reg;

endmodule

// File: tb/tb_pll_loop_filter.sv
// Directed bench for pll_loop_filter: table of single-strobe vectors plus
// hand-written sequences for saturation, lock/unlock, freeze, clear and reset.
module tb_pll_loop_filter;

  localparam logic [31:0] NOM = 32'h0147AE14;

  logic        clk;
  logic        reset_n;
  logic [15:0] phase_error;
  logic        error_valid;
  logic [1:0]  margin_zone;
  logic [31:0] center_freq;
  logic [3:0]  kp_shift;
  logic [3:0]  ki_shift;
  logic        freeze;
  logic        integ_clear;
  logic [31:0] nco_freq;
  logic        freq_valid;
  logic        locked;
  logic [1:0]  loop_state;
  logic        saturated;
`ifdef PLL_LOOP_FILTER_STATS_EN
  logic [15:0] unlock_count;
  logic [15:0] peak_error;
`endif

  int checks = 0;
  int errors = 0;

  pll_loop_filter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .phase_error (phase_error),
    .error_valid (error_valid),
    .margin_zone (margin_zone),
    .center_freq (center_freq),
    .kp_shift    (kp_shift),
    .ki_shift    (ki_shift),
    .freeze      (freeze),
    .integ_clear (integ_clear),
    .nco_freq    (nco_freq),
    .freq_valid  (freq_valid),
    .locked      (locked),
    .loop_state  (loop_state),
`ifdef PLL_LOOP_FILTER_STATS_EN
    .unlock_count(unlock_count),
    .peak_error  (peak_error),
`endif
    .saturated   (saturated)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] center;
    logic [15:0] pe;
    logic [3:0]  kp;
    logic [3:0]  ki;
    logic [31:0] exp_nco;
    logic        exp_sat;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end else begin
      $display("ok   %s = %08h", name, act);
    end
  endtask

  task automatic strobe(input logic [15:0] pe, input logic [1:0] zn);
    phase_error = pe;
    margin_zone = zn;
    error_valid = 1'b1;
    tick();
    error_valid = 1'b0;
  endtask

  task automatic do_clear();
    integ_clear = 1'b1;
    tick();
    integ_clear = 1'b0;
  endtask

  initial begin
    int fv_count;
    logic [1:0] zseq[8];
    logic       lseq[8];

    // center, pe, kp, ki, expected nco, expected saturated (ACQUIRE, boost 2)
    vecs[0] = '{NOM,          16'h1000, 4'd4,  4'd8,  32'h014BEE14, 1'b0};
    vecs[1] = '{NOM,          16'hF000, 4'd4,  4'd8,  32'h01436E14, 1'b0};
    vecs[2] = '{NOM,          16'h0001, 4'd0,  4'd0,  32'h0147B014, 1'b0};
    vecs[3] = '{NOM,          16'hFFFF, 4'd15, 4'd15, 32'h0147AE12, 1'b0};
    vecs[4] = '{NOM,          16'h0100, 4'd1,  4'd3,  32'h01492E14, 1'b0};
    vecs[5] = '{NOM,          16'h7FFF, 4'd4,  4'd4,  32'h0157AE14, 1'b1};
    vecs[6] = '{NOM,          16'h8000, 4'd6,  4'd15, 32'h013FAA14, 1'b0};
    vecs[7] = '{32'h10000000, 16'h1000, 4'd4,  4'd8,  32'h10044000, 1'b0};

    reset_n     = 1'b0;
    phase_error = 16'h0000;
    error_valid = 1'b0;
    margin_zone = 2'b00;
    center_freq = NOM;
    kp_shift    = 4'd4;
    ki_shift    = 4'd8;
    freeze      = 1'b0;
    integ_clear = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("reset_nco", nco_freq, NOM);
    check("reset_fv", 32'(freq_valid), 32'd0);
    check("reset_state", 32'(loop_state), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_sat", 32'(saturated), 32'd0);
`ifdef PLL_LOOP_FILTER_STATS_EN
    check("reset_unlock_count", 32'(unlock_count), 32'd0);
    check("reset_peak_error", 32'(peak_error), 32'd0);
`endif

    // Single strobes from a cleared integrator; latency is exactly two edges.
    for (int i = 0; i < 8; i++) begin
      center_freq = vecs[i].center;
      kp_shift    = vecs[i].kp;
      ki_shift    = vecs[i].ki;
      do_clear();
      check($sformatf("v%0d_clear_nco", i), nco_freq, vecs[i].center);
      strobe(vecs[i].pe, 2'b11);
      tick();
      check($sformatf("v%0d_fv_early", i), 32'(freq_valid), 32'd0);
      tick();
      check($sformatf("v%0d_fv", i), 32'(freq_valid), 32'd1);
      check($sformatf("v%0d_nco", i), nco_freq, vecs[i].exp_nco);
      check($sformatf("v%0d_sat", i), 32'(saturated), 32'(vecs[i].exp_sat));
      tick();
      check($sformatf("v%0d_fv_late", i), 32'(freq_valid), 32'd0);
    end
    center_freq = NOM;
    kp_shift    = 4'd4;
    ki_shift    = 4'd8;
    do_clear();
    check("v0_integ_ref", dut.integ_reg, 32'h0);

    // Back-to-back positive saturation, then negative.
    fv_count    = 0;
    phase_error = 16'h7FFF;
    margin_zone = 2'b11;
    error_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (freq_valid) fv_count++;
    end
    error_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (freq_valid) fv_count++;
    end
    check("sat_hi_fv_count", 32'(fv_count), 32'd20);
    check("sat_hi_nco", nco_freq, 32'h0157AE14);
    check("sat_hi_integ", dut.integ_reg, 32'h00080000);
    check("sat_hi_flag", 32'(saturated), 32'd1);
    phase_error = 16'h8000;
    error_valid = 1'b1;
    repeat (20) tick();
    error_valid = 1'b0;
    repeat (3) tick();
    check("sat_lo_nco", nco_freq, 32'h0137AE14);
    check("sat_lo_integ", dut.integ_reg, 32'hFFF80000);
    check("sat_lo_flag", 32'(saturated), 32'd1);

    // Lock after 16 on-time samples, unlock after 4 consecutive misses.
    do_clear();
    phase_error = 16'h0000;
    margin_zone = 2'b01;
    error_valid = 1'b1;
    repeat (16) tick();
    error_valid = 1'b0;
    check("lock_15_updates", 32'(locked), 32'd0);
    tick();
    check("lock_16_updates", 32'(locked), 32'd1);
    check("lock_state", 32'(loop_state), 32'd1);
    zseq[0] = 2'b11; zseq[1] = 2'b11; zseq[2] = 2'b11; zseq[3] = 2'b01;
    zseq[4] = 2'b11; zseq[5] = 2'b10; zseq[6] = 2'b00; zseq[7] = 2'b11;
    lseq[0] = 1'b1;  lseq[1] = 1'b1;  lseq[2] = 1'b1;  lseq[3] = 1'b1;
    lseq[4] = 1'b1;  lseq[5] = 1'b1;  lseq[6] = 1'b1;  lseq[7] = 1'b0;
    for (int j = 0; j < 8; j++) begin
      strobe(16'h0000, zseq[j]);
      tick();
      check($sformatf("unlock_seq%0d", j), 32'(locked), 32'(lseq[j]));
    end
    check("unlock_state", 32'(loop_state), 32'd0);

    // Freeze from LOCKED: samples dropped, output held, state restored.
    do_clear();
    margin_zone = 2'b01;
    error_valid = 1'b1;
    repeat (16) tick();
    error_valid = 1'b0;
    tick();
    check("relock", 32'(locked), 32'd1);
    strobe(16'h1000, 2'b01);
    tick();
    tick();
    check("locked_gain_fv", 32'(freq_valid), 32'd1);
    check("locked_gain_nco", nco_freq, 32'h0148BE14);
    freeze      = 1'b1;
    phase_error = 16'h7FFF;
    margin_zone = 2'b11;
    error_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("freeze%0d_fv", i), 32'(freq_valid), 32'd0);
      check($sformatf("freeze%0d_state", i), 32'(loop_state), 32'd2);
      check($sformatf("freeze%0d_nco", i), nco_freq, 32'h0148BE14);
    end
    freeze      = 1'b0;
    error_valid = 1'b0;
    tick();
    check("thaw_state", 32'(loop_state), 32'd1);
    check("thaw_locked", 32'(locked), 32'd1);
    tick();
    tick();
    check("thaw_fv", 32'(freq_valid), 32'd0);
    check("thaw_integ", dut.integ_reg, 32'h00001000);
    check("thaw_nco", nco_freq, 32'h0148BE14);

    // integ_clear together with error_valid discards the sample.
    phase_error = 16'h7FFF;
    error_valid = 1'b1;
    integ_clear = 1'b1;
    tick();
    error_valid = 1'b0;
    integ_clear = 1'b0;
    check("clr_nco", nco_freq, NOM);
    check("clr_state", 32'(loop_state), 32'd0);
    check("clr_integ", dut.integ_reg, 32'h0);
    tick();
    check("clr_fv1", 32'(freq_valid), 32'd0);
    tick();
    check("clr_fv2", 32'(freq_valid), 32'd0);

    // Asynchronous reset between stage 1 and stage 2.
    center_freq = 32'h02000000;
    do_clear();
    strobe(16'h1000, 2'b11);
    tick();
    reset_n = 1'b0;
    #2;
    check("rst_mid_nco", nco_freq, NOM);
    check("rst_mid_fv", 32'(freq_valid), 32'd0);
    check("rst_mid_state", 32'(loop_state), 32'd0);
    check("rst_mid_locked", 32'(locked), 32'd0);
    check("rst_mid_sat", 32'(saturated), 32'd0);
`ifdef PLL_LOOP_FILTER_STATS_EN
    check("rst_mid_unlock_count", 32'(unlock_count), 32'd0);
    check("rst_mid_peak_error", 32'(peak_error), 32'd0);
`endif
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_after%0d_fv", i), 32'(freq_valid), 32'd0);
    end
    check("rst_after_nco", nco_freq, NOM);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
